// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control FSM for a single-issue RV32I subset. It sequences
//   fetch, decode, execute, memory and write-back. It drives the ALU opcode,
//   the operand selects and the memory/register strobes. It reads the ALU
//   zero/minus flags to resolve conditional branches.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   instr      in   [31:0] instruction register contents
//   mem_ack    in   completion of the current memory request
//   alu_zero   in   ALU result == 0
//   alu_minus  in   ALU result bit 31
//   alu_op     out  [3:0] ALU operation code
//   alu_src_a  out  0 = PC, 1 = rs1 latch
//   alu_src_b  out  [1:0] 0 = rs2, 1 = const 4, 2 = I/S/U imm, 3 = B offset
//   pc_write   out  load PC this edge
//   pc_src     out  0 = ALU result, 1 = ALUOut register
//   ir_write   out  load instruction register
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   iord       out  0 = PC address, 1 = ALUOut address
//   reg_write  out  register-file write
//   mem_to_reg out  0 = ALU result, 1 = memory data
//   illegal    out  sticky unsupported-instruction flag
//
// Outputs are decoded from the state register. This keeps them glitch-free
// with respect to state and lets reset clear them at once. There are two
// exceptions. In FETCH, ir_write/pc_write follow mem_ack. In BRANCH,
// pc_write follows the ALU flags.
// -----------------------------------------------------------------------------
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ack,
   input  logic        alu_zero,
   input  logic        alu_minus,
   output logic [3:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        pc_write,
   output logic        pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_LUI = 4'b0100;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      EXEC_R   = 4'd3,
      EXEC_I   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      WB_MEM   = 4'd7,
      MEM_WR   = 4'd8,
      WB_ALU   = 4'd9,
      BRANCH   = 4'd10,
      LUI      = 4'd11,
      TRAP     = 4'd12
   } state_t;

   state_t     state_r;
   state_t     next_state_s;
   logic [4:0] r_dec_s;
   logic [4:0] i_dec_s;
   logic [1:0] br_dec_s;
   logic       unused_instr_s;

   // Register-register op decode. Returns {legal, alu_op}; unsupported
   // encodings report ADD on the bus while the FSM heads to TRAP.
   function automatic logic [4:0] decode_r(input logic [6:0] funct7,
                                           input logic [2:0] funct3);
      logic [4:0] res;
      case ({funct7, funct3})
         {7'b0000000, 3'b000}: res = {1'b1, OP_ADD};
         {7'b0100000, 3'b000}: res = {1'b1, OP_SUB};
         {7'b0000000, 3'b010}: res = {1'b1, OP_SLT};
         {7'b0000000, 3'b110}: res = {1'b1, OP_OR};
         {7'b0000000, 3'b111}: res = {1'b1, OP_AND};
         default:              res = {1'b0, OP_ADD};
      endcase
      return res;
   endfunction

   // Register-immediate op decode, same {legal, alu_op} packing.
   function automatic logic [4:0] decode_i(input logic [2:0] funct3);
      logic [4:0] res;
      case (funct3)
         3'b000:  res = {1'b1, OP_ADD};
         3'b010:  res = {1'b1, OP_SLT};
         3'b110:  res = {1'b1, OP_OR};
         3'b111:  res = {1'b1, OP_AND};
         default: res = {1'b0, OP_ADD};
      endcase
      return res;
   endfunction

   // Branch condition from the SUB flags. Returns {legal, take}. Signed
   // overflow is not corrected, so BLT/BGE trust the raw sign bit.
   function automatic logic [1:0] branch_eval(input logic [2:0] funct3,
                                              input logic       zero,
                                              input logic       minus);
      logic [1:0] res;
      case (funct3)
         3'b000:  res = {1'b1, zero};
         3'b001:  res = {1'b1, ~zero};
         3'b100:  res = {1'b1, minus};
         3'b101:  res = {1'b1, ~minus};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

   assign r_dec_s  = decode_r(instr[31:25], instr[14:12]);
   assign i_dec_s  = decode_i(instr[14:12]);
   assign br_dec_s = branch_eval(instr[14:12], alu_zero, alu_minus);

   // Register indices and immediate bits belong to the datapath, not here.
   assign unused_instr_s = ^{instr[24:15], instr[11:7]};

   // State register, cleared asynchronously to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and output decode.
   always_comb begin
      next_state_s = state_r;
      alu_op       = OP_AND;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      illegal      = 1'b0;

      case (state_r)
         IDLE: begin
            next_state_s = FETCH;
         end
         FETCH: begin
            mem_read  = 1'b1;
            alu_op    = OP_ADD;
            alu_src_b = 2'd1;
            // PC+4 and the instruction are captured on the ack edge.
            if (mem_ack) begin
               ir_write     = 1'b1;
               pc_write     = 1'b1;
               next_state_s = DECODE;
            end else begin
               next_state_s = FETCH;
            end
         end
         DECODE: begin
            // Precompute the branch target into ALUOut.
            alu_op    = OP_ADD;
            alu_src_b = 2'd3;
            case (instr[6:0])
               OPC_R:      next_state_s = EXEC_R;
               OPC_I:      next_state_s = EXEC_I;
               OPC_LOAD:   next_state_s = MEM_ADDR;
               OPC_STORE:  next_state_s = MEM_ADDR;
               OPC_BRANCH: next_state_s = BRANCH;
               OPC_LUI:    next_state_s = LUI;
               default:    next_state_s = TRAP;
            endcase
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            alu_op    = r_dec_s[3:0];
            if (r_dec_s[4]) begin
               next_state_s = WB_ALU;
            end else begin
               next_state_s = TRAP;
            end
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = i_dec_s[3:0];
            if (i_dec_s[4]) begin
               next_state_s = WB_ALU;
            end else begin
               next_state_s = TRAP;
            end
         end
         WB_ALU: begin
            // Keep the execute-stage op and selects so the result stays
            // valid at the write edge. instr[5] tells R-type from I-type.
            reg_write = 1'b1;
            alu_src_a = 1'b1;
            if (instr[5]) begin
               alu_op    = r_dec_s[3:0];
               alu_src_b = 2'd0;
            end else begin
               alu_op    = i_dec_s[3:0];
               alu_src_b = 2'd2;
            end
            next_state_s = FETCH;
         end
         MEM_ADDR: begin
            alu_op    = OP_ADD;
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            // Loads and stores differ only in opcode bit 5.
            if (instr[5]) begin
               next_state_s = MEM_WR;
            end else begin
               next_state_s = MEM_RD;
            end
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ack) begin
               next_state_s = WB_MEM;
            end else begin
               next_state_s = MEM_RD;
            end
         end
         WB_MEM: begin
            reg_write    = 1'b1;
            mem_to_reg   = 1'b1;
            next_state_s = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ack) begin
               next_state_s = FETCH;
            end else begin
               next_state_s = MEM_WR;
            end
         end
         BRANCH: begin
            alu_op    = OP_SUB;
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            pc_src    = 1'b1;
            pc_write  = br_dec_s[0];
            if (br_dec_s[1]) begin
               next_state_s = FETCH;
            end else begin
               next_state_s = TRAP;
            end
         end
         LUI: begin
            alu_op       = OP_LUI;
            alu_src_b    = 2'd2;
            reg_write    = 1'b1;
            next_state_s = FETCH;
         end
         TRAP: begin
            // Only reset leaves TRAP, so the flag stays set until then.
            illegal      = 1'b1;
            next_state_s = TRAP;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. For each instruction, a reference
//   model expands it into the expected cycle-by-cycle output trace. The trace
//   comes from the instruction class, the funct tables and the chosen memory
//   ack delays. Each trace entry also holds the mem_ack/flag stimulus for
//   that cycle. Outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0111;
   localparam logic [3:0] A_LUI = 4'b0100;

   // Strobe groups {pc_write,pc_src,ir_write, mem_read,mem_write,iord,
   //                reg_write,mem_to_reg,illegal}
   localparam logic [8:0] ST_NONE   = 9'b000_000_000;
   localparam logic [8:0] ST_FWAIT  = 9'b000_100_000;
   localparam logic [8:0] ST_FACK   = 9'b101_100_000;
   localparam logic [8:0] ST_MRD    = 9'b000_101_000;
   localparam logic [8:0] ST_MWR    = 9'b000_011_000;
   localparam logic [8:0] ST_WB     = 9'b000_000_100;
   localparam logic [8:0] ST_WBMEM  = 9'b000_000_110;
   localparam logic [8:0] ST_BR     = 9'b010_000_000;
   localparam logic [8:0] ST_TRAP   = 9'b000_000_001;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        mem_ack;
   logic        alu_zero;
   logic        alu_minus;
   logic [3:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        pc_write;
   logic        pc_src;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        iord;
   logic        reg_write;
   logic        mem_to_reg;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ins;
      logic        ack;
      int          flg;   // -1: random flags, else {zero, minus}
      int          br;    // -1: pc_write as in exp, else branch funct3
      logic [15:0] exp;
   } cyc_t;

   cyc_t        q[$];
   logic [31:0] cur_ins = 32'h0;
   int          cur_flg = -1;

   multicycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .mem_ack    (mem_ack),
      .alu_zero   (alu_zero),
      .alu_minus  (alu_minus),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .iord       (iord),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic rnd1();
      return ($urandom_range(0, 1) == 1);
   endfunction

   function automatic logic [15:0] pk(input logic [3:0] op, input logic sa,
                                      input logic [1:0] sb, input logic [8:0] st);
      return {op, sa, sb, st};
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic m);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return m;
         3'b101:  return !m;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] observe();
      return {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
              mem_read, mem_write, iord, reg_write, mem_to_reg, illegal};
   endfunction

   task automatic add_rec(input logic ack, input logic [15:0] e, input int br);
      cyc_t c;
      c.ins = cur_ins;
      c.ack = ack;
      c.flg = cur_flg;
      c.br  = br;
      c.exp = e;
      q.push_back(c);
   endtask

   task automatic push_idle(input logic ack);
      add_rec(ack, 16'h0000, -1);
   endtask

   task automatic push_trap(input int n);
      for (int i = 0; i < n; i++) add_rec(rnd1(), pk(4'h0, 1'b0, 2'd0, ST_TRAP), -1);
   endtask

   // Reference model: expected trace of one instruction. df/dm are the
   // extra wait cycles before mem_ack in fetch and in the data access.
   task automatic expect_instr(input logic [31:0] ins, input int df, input int dm);
      logic [3:0] op;
      logic       ok;
      logic [2:0] f3;
      f3      = ins[14:12];
      cur_ins = ins;
      for (int i = 0; i < df; i++) add_rec(1'b0, pk(A_ADD, 1'b0, 2'd1, ST_FWAIT), -1);
      add_rec(1'b1, pk(A_ADD, 1'b0, 2'd1, ST_FACK), -1);
      add_rec(rnd1(), pk(A_ADD, 1'b0, 2'd3, ST_NONE), -1);
      case (ins[6:0])
         7'b0110011: begin
            ok = 1'b1;
            case ({ins[31:25], f3})
               10'b0000000_000: op = A_ADD;
               10'b0100000_000: op = A_SUB;
               10'b0000000_010: op = A_SLT;
               10'b0000000_110: op = A_OR;
               10'b0000000_111: op = A_AND;
               default: begin ok = 1'b0; op = A_ADD; end
            endcase
            add_rec(rnd1(), pk(op, 1'b1, 2'd0, ST_NONE), -1);
            if (ok) add_rec(rnd1(), pk(op, 1'b1, 2'd0, ST_WB), -1);
            else    push_trap(5);
         end
         7'b0010011: begin
            ok = 1'b1;
            case (f3)
               3'b000:  op = A_ADD;
               3'b010:  op = A_SLT;
               3'b110:  op = A_OR;
               3'b111:  op = A_AND;
               default: begin ok = 1'b0; op = A_ADD; end
            endcase
            add_rec(rnd1(), pk(op, 1'b1, 2'd2, ST_NONE), -1);
            if (ok) add_rec(rnd1(), pk(op, 1'b1, 2'd2, ST_WB), -1);
            else    push_trap(5);
         end
         7'b0000011: begin
            add_rec(rnd1(), pk(A_ADD, 1'b1, 2'd2, ST_NONE), -1);
            for (int i = 0; i < dm; i++) add_rec(1'b0, pk(4'h0, 1'b0, 2'd0, ST_MRD), -1);
            add_rec(1'b1, pk(4'h0, 1'b0, 2'd0, ST_MRD), -1);
            add_rec(rnd1(), pk(4'h0, 1'b0, 2'd0, ST_WBMEM), -1);
         end
         7'b0100011: begin
            add_rec(rnd1(), pk(A_ADD, 1'b1, 2'd2, ST_NONE), -1);
            for (int i = 0; i < dm; i++) add_rec(1'b0, pk(4'h0, 1'b0, 2'd0, ST_MWR), -1);
            add_rec(1'b1, pk(4'h0, 1'b0, 2'd0, ST_MWR), -1);
         end
         7'b1100011: begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
            add_rec(rnd1(), pk(A_SUB, 1'b1, 2'd0, ST_BR), ok ? int'(f3) : -1);
            if (!ok) push_trap(5);
         end
         7'b0110111: begin
            add_rec(rnd1(), pk(A_LUI, 1'b0, 2'd2, ST_WB), -1);
         end
         default: push_trap(5);
      endcase
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          j;
      r = $urandom;
      j = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
         0: begin
            case ($urandom_range(0, 4))
               0:       begin f7 = 7'b0000000; f3 = 3'b000; end
               1:       begin f7 = 7'b0100000; f3 = 3'b000; end
               2:       begin f7 = 7'b0000000; f3 = 3'b010; end
               3:       begin f7 = 7'b0000000; f3 = 3'b110; end
               default: begin f7 = 7'b0000000; f3 = 3'b111; end
            endcase
            return {f7, r[24:15], f3, r[11:7], 7'b0110011};
         end
         1: begin
            f3 = (j == 0) ? 3'b000 : (j == 1) ? 3'b010 : (j == 2) ? 3'b110 : 3'b111;
            return {r[31:15], f3, r[11:7], 7'b0010011};
         end
         2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
         3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
         4: begin
            f3 = (j == 0) ? 3'b000 : (j == 1) ? 3'b001 : (j == 2) ? 3'b100 : 3'b101;
            return {r[31:15], f3, r[11:7], 7'b1100011};
         end
         default: return {r[31:7], 7'b0110111};
      endcase
   endfunction

   // Drive one queued cycle and return observed and expected outputs.
   task automatic run_one(output logic [15:0] obs, output logic [15:0] exp);
      cyc_t c;
      c = q.pop_front();
      @(negedge clk);
      instr   = c.ins;
      mem_ack = c.ack;
      if (c.flg < 0) begin
         alu_zero  = rnd1();
         alu_minus = rnd1();
      end else begin
         alu_zero  = c.flg[1];
         alu_minus = c.flg[0];
      end
      #1;
      obs = observe();
      exp = c.exp;
      if (c.br >= 0) exp[8] = br_taken(c.br[2:0], alu_zero, alu_minus);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] obs, exp;
      int n = 0;
      rst = 1'b0; mem_ack = 1'b1; instr = 32'h0; alu_zero = 1'b0; alu_minus = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (observe() !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0000", observe());
      end
      @(posedge clk);
      #2 rst = 1'b1;
      cur_ins = 32'h002081B3;
      push_idle(1'b1);
      expect_instr(32'h002081B3, 0, 0);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_add cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_alu();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      push_idle(rnd1());
      expect_instr(32'h40208033, 0, 0);
      expect_instr(32'h0020F033, 1, 0);
      expect_instr(32'h0020A1B3, 0, 0);
      expect_instr(32'h0020E1B3, 2, 0);
      expect_instr(32'h00508093, 0, 0);
      expect_instr(32'h123450B7, 0, 0);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL alu cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_mem();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      push_idle(rnd1());
      expect_instr(32'h0000A183, 0, 2);
      expect_instr(32'h0020A023, 0, 0);
      expect_instr(32'h0020A223, 1, 3);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL mem cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_branch();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      push_idle(rnd1());
      cur_flg = 2; expect_instr(32'h00208463, 0, 0);   // BEQ, zero=1
      cur_flg = 0; expect_instr(32'h00208463, 0, 0);   // BEQ, zero=0
      cur_flg = 1; expect_instr(32'h0020C463, 0, 0);   // BLT, minus=1
      cur_flg = 1; expect_instr(32'h0020D463, 0, 0);   // BGE, minus=1
      cur_flg = 0; expect_instr(32'h00209463, 0, 0);   // BNE, zero=0
      cur_flg = -1; expect_instr(32'h0020A463, 0, 0);  // bad funct3 -> TRAP
      cur_flg = -1;
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL branch cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_trap();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      push_idle(rnd1());
      expect_instr(32'hFFFFFFFF, 0, 0);
      push_trap(15);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL trap cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (observe() !== 16'h0000) begin
         failures++;
         $display("FAIL trap_reset_clear: got %h expected 0000", observe());
      end
      @(posedge clk);
      #2 rst = 1'b1;
      push_idle(rnd1());
      expect_instr(32'h002081B3, 0, 0);
      expect_instr(32'h02208033, 0, 0);                 // unsupported funct7 -> TRAP
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL trap_resume cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid_fetch();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      cur_ins = 32'h002081B3;
      push_idle(1'b0);
      add_rec(1'b0, pk(A_ADD, 1'b0, 2'd1, ST_FWAIT), -1);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL mid_fetch_pre cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || observe() !== 16'h0000) begin
         failures++;
         $display("FAIL mid_fetch_drop: got %h expected 0000", observe());
      end
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (observe() !== 16'h0000) begin
         failures++;
         $display("FAIL ack_in_reset: got %h expected 0000", observe());
      end
      mem_ack = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      push_idle(1'b1);                                  // late ack, must be ignored
      expect_instr(32'h0000A183, 1, 0);
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL mid_fetch_post cycle %0d: got %h expected %h", n, obs, exp);
         end
         n++;
      end
   endtask

   task automatic test_random();
      logic [15:0] obs, exp;
      int n = 0;
      do_reset();
      push_idle(rnd1());
      for (int i = 0; i < 60; i++) begin
         expect_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      while (q.size() > 0) begin
         run_one(obs, exp);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL random cycle %0d ins %h: got %h expected %h", n, instr, obs, exp);
         end
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_trap();
      test_reset_mid_fetch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
